axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator: the master-side counterpart of the demo_axi_streams AXI-Lite slave register port.
- Converts a simple valid/ready command port (read or write, one word) into AXI-Lite channel traffic and returns the read data and response on a valid/ready response port.
- Used as a register-access engine inside designs and as the bus driver in slave test harnesses.
- Per-transaction timeout guards against a hung slave.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be a multiple of 8.
- STROBE_WIDTH, DATA_WIDTH/8, write strobe width.
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction before abort; 0 disables the timeout.

Ports:
- i_axi_clk  in  1  clock
- i_axi_rst  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_rnw  in  1  1=read, 0=write
- i_cmd_addr  in  ADDR_WIDTH  target address
- i_cmd_wdata  in  DATA_WIDTH  write data
- i_cmd_wstrb  in  STROBE_WIDTH  write strobes
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumer ready
- o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- o_rsp_resp  out  2  AXI response code
- o_rsp_timeout  out  1  transaction aborted by timeout
- o_awvalid  out  1  write-address valid
- i_awready  in  1  write-address ready
- o_awaddr  out  ADDR_WIDTH  write address
- o_wvalid  out  1  write-data valid
- i_wready  in  1  write-data ready
- o_wdata  out  DATA_WIDTH  write data
- o_wstrb  out  STROBE_WIDTH  write strobes
- i_bvalid  in  1  write-response valid
- o_bready  out  1  write-response ready
- i_bresp  in  2  write response
- o_arvalid  out  1  read-address valid
- i_arready  in  1  read-address ready
- o_araddr  out  ADDR_WIDTH  read address
- i_rvalid  in  1  read-data valid
- o_rready  out  1  read-data ready
- i_rresp  in  2  read response
- i_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset (i_axi_rst low, asynchronous): all outputs 0, state IDLE, timeout counter 0.
  - o_cmd_ready rises the first cycle after reset release.
  - Reset asserted mid-transaction aborts immediately; no response is produced.
- All outputs are registered.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid, command is latched; o_cmd_ready drops the next cycle.
  - rnw=0 goes to WR_ADDR_DATA: o_awvalid and o_wvalid both assert the next cycle.
  - rnw=1 goes to RD_ADDR: o_arvalid asserts the next cycle.
- WR_ADDR_DATA:
  - AW and W complete independently. Each valid drops the cycle after its own handshake.
  - Simultaneous AW and W handshake in the same cycle is legal.
  - Once both are done: go to WR_RESP with o_bready=1.
- WR_RESP:
  - On i_bvalid&o_bready: capture i_bresp, rdata=0, drop o_bready, go to RSP.
- RD_ADDR:
  - On i_arready: drop o_arvalid, assert o_rready, go to RD_DATA.
- RD_DATA:
  - On i_rvalid&o_rready: capture i_rdata and i_rresp, drop o_rready, go to RSP.
- RSP:
  - o_rsp_valid=1 with fields held stable until i_rsp_ready.
  - Then o_rsp_valid=0 and state returns to IDLE; o_cmd_ready=1 that same next cycle.
  - Minimum command-to-command spacing with a zero-wait slave: write 5 cycles, read 5 cycles.
- Address, data and strobe outputs hold the latched command for the whole transaction.
- Outputs are 0 in IDLE.
- Slave ready signals arriving before valid are ignored; no combinational ready-to-valid path.
- Timeout:
  - Counter clears on command accept and increments every cycle in the AXI states (not RSP).
  - Reaching TIMEOUT_CYCLES: deassert all AXI valids/readies, o_rsp_resp=2'b10, o_rsp_timeout=1, rdata=0, go to RSP.
  - A handshake completing in the same cycle as expiry wins; no timeout is reported.
  - A late slave response after abort is not accepted because the readies are low.
  - The abort is a recovery path, not AXI-compliant.
- o_rsp_timeout=0 for every normal completion.
- SLVERR/DECERR responses from the slave are passed through unchanged.

Test Plan:
- Write addr 0x10, data 0xA5A5_1234, strb 0xF, slave with zero waits:
  - AW and W accepted the same cycle, B=OKAY.
  - Response resp=0, timeout=0, rdata=0.
  - o_cmd_ready back high 5 cycles after accept.
- Write with awready delayed 3 cycles and wready immediate:
  - o_wvalid drops after 1 cycle; o_awvalid stays high until its handshake.
  - o_bready asserts only after both complete.
- Read addr 0x04, slave returns 0xDEAD_BEEF with rresp=2'b10 after 2 wait cycles:
  - rsp_rdata=0xDEAD_BEEF, rsp_resp=2'b10, timeout=0.
- TIMEOUT_CYCLES=8, slave never asserts arready:
  - o_arvalid drops after 8 cycles.
  - Response resp=2'b10, timeout=1, rdata=0; the next command is accepted normally.
- Hold i_rsp_ready low for 4 cycles:
  - Response fields stable, o_cmd_ready stays 0, no new AXI activity.
- Assert reset during WR_RESP:
  - All outputs 0 immediately (asynchronous).
  - After release, a read to 0x08 completes correctly.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator. A valid/ready command port is turned
// into AW/W/B or AR/R channel traffic. The result comes back on a valid/ready
// response port. A per-transaction cycle budget aborts transfers to a hung slave.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_rnw,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [STROBE_WIDTH-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [1:0]              i_rresp,
  input  logic [DATA_WIDTH-1:0]   i_rdata
);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            resp;
    logic                  timeout;
  } rsp_t;

  // Counter is wide enough to hold TIMEOUT_CYCLES itself; it saturates there.
  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0]   TMO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
  rsp_t                    rsp_q, rsp_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, axi_busy, expired;

  assign aw_hs    = awvalid_q & i_awready;
  assign w_hs     = wvalid_q & i_wready;
  assign b_hs     = bready_q & i_bvalid;
  assign ar_hs    = arvalid_q & i_arready;
  assign r_hs     = rready_q & i_rvalid;
  assign any_hs   = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign axi_busy = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                    (state_q == RD_ADDR) || (state_q == RD_DATA);
  // A handshake landing on the last budgeted cycle takes priority over the abort.
  assign expired  = TMO_EN && axi_busy && (cnt_q >= TMO_LAST) && !any_hs;

  // State and every output register; reset clears everything, aborting any transfer.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_q       <= rsp_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-output logic; every output is the registered copy of its _d.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_d       = rsp_q;
    cnt_d       = cnt_q;

    if (axi_busy && cnt_q != TMO_MAX) cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (i_cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (i_cmd_rnw) begin
            arvalid_d = 1'b1;
            araddr_d  = i_cmd_addr;
            state_d   = RD_ADDR;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = i_cmd_addr;
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_wstrb;
            state_d   = WR_ADDR_DATA;
          end
        end
      end
      WR_ADDR_DATA: begin
        // A channel whose valid is already low has completed earlier.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_d       = '{rdata: '0, resp: i_bresp, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_d       = '{rdata: i_rdata, resp: i_rresp, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          awaddr_d    = '0;
          araddr_d    = '0;
          wdata_d     = '0;
          wstrb_d     = '0;
          rsp_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Recovery abort: drop every channel so a late slave beat is never accepted.
    if (expired) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_d       = '{rdata: '0, resp: 2'b10, timeout: 1'b1};
      rsp_valid_d = 1'b1;
      state_d     = RSP;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_q.rdata;
  assign o_rsp_resp    = rsp_q.resp;
  assign o_rsp_timeout = rsp_q.timeout;
  assign o_awvalid     = awvalid_q;
  assign o_awaddr      = awaddr_q;
  assign o_wvalid      = wvalid_q;
  assign o_wdata       = wdata_q;
  assign o_wstrb       = wstrb_q;
  assign o_bready      = bready_q;
  assign o_arvalid     = arvalid_q;
  assign o_araddr      = araddr_q;
  assign o_rready      = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: configurable-latency slave, response consumer with
// a scoreboard of expected {rdata, resp, timeout}, and cycle-exact channel checks.
module tb_axi_lite_master;

  logic        clk, rst_n;
  logic        i_cmd_valid, i_cmd_rnw;
  logic [31:0] i_cmd_addr, i_cmd_wdata;
  logic [3:0]  i_cmd_wstrb;
  logic        o_cmd_ready, o_rsp_valid, i_rsp_ready, o_rsp_timeout;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [31:0] o_awaddr, o_wdata, o_araddr, i_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
    .i_axi_clk(clk), .i_axi_rst(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_rnw(i_cmd_rnw),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0, rsp_hold = 0;
  int rsp_seen = 0;
  logic [34:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Slave channels: ready/valid rises once the master side has waited *_delay cycles.
  initial begin
    int aw_w, w_w, b_w, ar_w, r_w;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0;
    forever begin
      @(negedge clk);
      if (o_awvalid) begin i_awready = (aw_w >= aw_delay); aw_w++; end else begin i_awready = 0; aw_w = 0; end
      if (o_wvalid)  begin i_wready  = (w_w  >= w_delay);  w_w++;  end else begin i_wready  = 0; w_w  = 0; end
      if (o_bready)  begin i_bvalid  = (b_w  >= b_delay);  b_w++;  end else begin i_bvalid  = 0; b_w  = 0; end
      if (o_arvalid) begin i_arready = (ar_w >= ar_delay); ar_w++; end else begin i_arready = 0; ar_w = 0; end
      if (o_rready)  begin i_rvalid  = (r_w  >= r_delay);  r_w++;  end else begin i_rvalid  = 0; r_w  = 0; end
    end
  end

  // Response consumer: stalls rsp_hold cycles, checks stability while stalled,
  // and pops the scoreboard on each accepted response.
  initial begin
    int wt;
    logic [34:0] snap, e;
    wt = 0; snap = '0; i_rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (rst_n && o_rsp_valid) begin
        if (wt == 0) snap = {o_rsp_rdata, o_rsp_resp, o_rsp_timeout};
        else begin
          chk("rsp_stable", 64'({o_rsp_rdata, o_rsp_resp, o_rsp_timeout}), 64'(snap));
          chk("hold_cmd_ready", 64'(o_cmd_ready), 64'(0));
          chk("hold_no_axi", 64'(o_awvalid | o_wvalid | o_arvalid | o_bready | o_rready), 64'(0));
        end
        i_rsp_ready = (wt >= rsp_hold);
        wt++;
        if (i_rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", 64'(o_rsp_rdata), 64'(e[34:3]));
            chk("rsp_resp", 64'(o_rsp_resp), 64'(e[2:1]));
            chk("rsp_timeout", 64'(o_rsp_timeout), 64'(e[0]));
          end
          rsp_seen++;
        end
      end else begin
        i_rsp_ready = 0;
        wt = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [34:0] exp);
    int n = 0;
    while (!o_cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 64'(o_cmd_ready), 64'(1));
    i_cmd_valid = 1; i_cmd_rnw = rnw; i_cmd_addr = addr; i_cmd_wdata = wd; i_cmd_wstrb = st;
    exp_q.push_back(exp);
    @(negedge clk);
    i_cmd_valid = 0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 200) begin @(negedge clk); n++; end
    chk("rsp_arrived", 64'(rsp_seen >= target), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_cmd_valid = 0; i_cmd_rnw = 0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
    i_bresp = 2'b00; i_rresp = 2'b00; i_rdata = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs_zero", 64'(|{o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_timeout,
        o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready, o_arvalid, o_araddr, o_rready}), 64'(0));
    rst_n = 1;
    #1 chk("rst_cmd_ready_low", 64'(o_cmd_ready), 64'(0));
    @(negedge clk);
    chk("cmd_ready_rise", 64'(o_cmd_ready), 64'(1));

    // Zero-wait write: AW and W in the same cycle, OKAY.
    issue(0, 32'h10, 32'hA5A5_1234, 4'hF, {32'h0, 2'b00, 1'b0});
    chk("t1_awvalid", 64'(o_awvalid), 64'(1));
    chk("t1_wvalid", 64'(o_wvalid), 64'(1));
    chk("t1_awaddr", 64'(o_awaddr), 64'(32'h10));
    chk("t1_wdata", 64'(o_wdata), 64'(32'hA5A5_1234));
    chk("t1_wstrb", 64'(o_wstrb), 64'(4'hF));
    chk("t1_cmd_ready_drop", 64'(o_cmd_ready), 64'(0));
    @(negedge clk);
    chk("t1_aw_w_done", 64'({o_awvalid, o_wvalid, o_bready}), 64'(3'b001));
    @(negedge clk);
    chk("t1_rsp_valid", 64'({o_rsp_valid, o_bready, o_cmd_ready}), 64'(3'b100));
    @(negedge clk);
    // Accept cycle counted as the first, ready is back on the fifth.
    chk("t1_cmd_ready_5cyc", 64'(o_cmd_ready), 64'(1));
    chk("t1_idle_zero", 64'({o_awaddr, o_wdata, o_rsp_rdata, o_rsp_valid}), 64'(0));
    wait_rsp(1);

    // awready delayed 3 cycles, wready immediate, DECERR passed through.
    aw_delay = 3; i_bresp = 2'b11;
    issue(0, 32'h24, 32'h0000_BEEF, 4'h3, {32'h0, 2'b11, 1'b0});
    chk("t2_both_valid", 64'({o_awvalid, o_wvalid}), 64'(2'b11));
    @(negedge clk);
    chk("t2_w_dropped", 64'({o_awvalid, o_wvalid, o_bready}), 64'(3'b100));
    @(negedge clk);
    chk("t2_aw_held", 64'({o_awvalid, o_bready}), 64'(2'b10));
    @(negedge clk);
    chk("t2_aw_held2", 64'({o_awvalid, o_bready}), 64'(2'b10));
    @(negedge clk);
    chk("t2_bready_after_both", 64'({o_awvalid, o_bready}), 64'(2'b01));
    wait_rsp(2);
    aw_delay = 0; i_bresp = 2'b00;

    // Read with 2 wait cycles on R, SLVERR passed through.
    r_delay = 2; i_rdata = 32'hDEAD_BEEF; i_rresp = 2'b10;
    issue(1, 32'h04, 32'h0, 4'h0, {32'hDEAD_BEEF, 2'b10, 1'b0});
    chk("t3_arvalid", 64'({o_arvalid, o_awvalid}), 64'(2'b10));
    chk("t3_araddr", 64'(o_araddr), 64'(32'h04));
    @(negedge clk);
    chk("t3_rready", 64'({o_arvalid, o_rready}), 64'(2'b01));
    wait_rsp(3);
    r_delay = 0;

    // Slave never accepts AR: abort after 8 cycles of arvalid.
    ar_delay = 1000;
    issue(1, 32'h30, 32'h0, 4'h0, {32'h0, 2'b10, 1'b1});
    repeat (7) @(negedge clk);
    chk("t4_arvalid_cycle8", 64'(o_arvalid), 64'(1));
    @(negedge clk);
    chk("t4_abort", 64'({o_arvalid, o_rready, o_rsp_valid}), 64'(3'b001));
    wait_rsp(4);
    ar_delay = 0;
    i_rdata = 32'h1234_5678; i_rresp = 2'b00;
    issue(1, 32'h0C, 32'h0, 4'h0, {32'h1234_5678, 2'b00, 1'b0});
    wait_rsp(5);

    // Consumer stalls 4 cycles on a read response.
    rsp_hold = 4; i_rdata = 32'hCAFE_F00D;
    issue(1, 32'h14, 32'h0, 4'h0, {32'hCAFE_F00D, 2'b00, 1'b0});
    wait_rsp(6);
    rsp_hold = 0;

    // Reset while waiting on B: outputs clear at once, no response appears.
    b_delay = 5;
    issue(0, 32'h20, 32'h5555_AAAA, 4'hF, {32'h0, 2'b00, 1'b0});
    n = 0;
    while (!o_bready && n < 20) begin @(negedge clk); n++; end
    chk("t6_in_wr_resp", 64'(o_bready), 64'(1));
    #2 rst_n = 0;
    #1 chk("t6_async_zero", 64'(|{o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_timeout,
        o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready, o_arvalid, o_araddr, o_rready}), 64'(0));
    exp_q.delete();
    b_delay = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t6_cmd_ready_after_rst", 64'(o_cmd_ready), 64'(1));
    i_rdata = 32'h0BAD_CAFE;
    issue(1, 32'h08, 32'h0, 4'h0, {32'h0BAD_CAFE, 2'b00, 1'b0});
    chk("t6_araddr", 64'(o_araddr), 64'(32'h08));
    wait_rsp(7);
    repeat (3) @(negedge clk);
    chk("t6_no_extra_rsp", 64'(rsp_seen), 64'(7));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
